// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if: client request/response bundle plus the DDR3 controller user-interface
// signals that the arbiter multiplexes.
interface dram_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 64
);
    logic [NUM_PORTS-1:0]        req_i;
    logic [NUM_PORTS-1:0]        we_i;
    logic [NUM_PORTS*ADDR_W-1:0] addr_i;
    logic [NUM_PORTS*DATA_W-1:0] wdata_i;
    logic [NUM_PORTS-1:0]        gnt_o;
    logic [NUM_PORTS-1:0]        done_o;
    logic [DATA_W-1:0]           rdata_o;
    logic                        err_o;
    logic                        mc_read_o;
    logic                        mc_write_o;
    logic [ADDR_W-1:0]           mc_address_o;
    logic [DATA_W-1:0]           mc_write_data_o;
    logic [DATA_W-1:0]           mc_read_data_i;
    logic                        mc_busy_i;
    modport slave (
        input  req_i, we_i, addr_i, wdata_i, mc_read_data_i, mc_busy_i,
        output gnt_o, done_o, rdata_o, err_o, mc_read_o, mc_write_o, mc_address_o, mc_write_data_o
    );
    modport master (
        output req_i, we_i, addr_i, wdata_i, mc_read_data_i, mc_busy_i,
        input  gnt_o, done_o, rdata_o, err_o, mc_read_o, mc_write_o, mc_address_o, mc_write_data_o
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one single-transaction DDR3 controller port among NUM_PORTS clients.
// Round-robin by default; define DRAM_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module dram_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dram_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(TIMEOUT) + 1;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE} state_t;
    state_t            r_state, w_next;
    logic [PW-1:0]     r_port, w_win;
    logic              r_we, r_err, w_grant, w_tmo, w_strobe;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [CW-1:0]     r_cnt;
`ifdef DRAM_ARB_FIXED_PRIORITY_EN
    always_comb begin
        w_win = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (bus.req_i[i]) w_win = PW'(i);
    end
`else
    logic [PW-1:0] r_last;
    logic [PW:0]   w_j;
    // Scan farthest-first so the requester nearest after r_last is written last and wins
    always_comb begin
        w_win = '0;
        w_j   = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            w_j = {1'b0, r_last} + (PW+1)'(i);
            w_j = w_j >= (PW+1)'(NUM_PORTS) ? w_j - (PW+1)'(NUM_PORTS) : w_j;
            if (bus.req_i[w_j[PW-1:0]]) w_win = w_j[PW-1:0];
        end
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) r_last <= PW'(NUM_PORTS - 1);
        else if (w_grant) r_last <= w_win;
`endif
    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_tmo    = 1'b0;
        w_strobe = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant = !bus.mc_busy_i && |bus.req_i;
                w_next  = w_grant ? ISSUE : IDLE;
            end
            ISSUE: begin
                w_strobe = 1'b1;
                w_next   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                w_tmo    = !bus.mc_busy_i && r_cnt == CW'(TIMEOUT - 1);
                w_strobe = !w_tmo;
                w_next   = bus.mc_busy_i ? WAIT_DONE : w_tmo ? IDLE : WAIT_BUSY;
            end
            WAIT_DONE: w_next = bus.mc_busy_i ? WAIT_DONE : CAPTURE;
            default:   w_next = IDLE;
        endcase
    end
    // Grant is combinational, so mask it while reset is held to keep every output quiet
    assign bus.gnt_o           = w_grant && !rst_i ? NUM_PORTS'(1) << w_win : '0;
    assign bus.done_o          = r_state == CAPTURE || w_tmo ? NUM_PORTS'(1) << r_port : '0;
    assign bus.rdata_o         = r_state == CAPTURE && !r_we ? bus.mc_read_data_i : r_rdata;
    assign bus.err_o           = r_err;
    assign bus.mc_write_o      = w_strobe && r_we;
    assign bus.mc_read_o       = w_strobe && !r_we;
    assign bus.mc_address_o    = r_addr;
    assign bus.mc_write_data_o = r_wdata;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_port  <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_port  <= w_win;
                r_we    <= bus.we_i[w_win];
                r_addr  <= bus.addr_i[w_win*ADDR_W +: ADDR_W];
                r_wdata <= bus.wdata_i[w_win*DATA_W +: DATA_W];
            end
            // Saturate rather than wrap so a stuck controller can never re-arm the timeout
            r_cnt <= r_state == ISSUE ? '0 :
                     r_state == WAIT_BUSY && r_cnt != '1 ? r_cnt + 1'b1 : r_cnt;
            r_err <= r_err || w_tmo;
            if (r_state == CAPTURE && !r_we) r_rdata <= bus.mc_read_data_i;
        end
    end
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: scoreboard bench with a behavioural DDR3 controller busy/read-data model.
module tb_dram_port_arbiter;
    localparam int NP = 4;
    localparam int AW = 27;
    localparam int DW = 64;
    localparam int TO = 1024;
    localparam int BL = 20;
    typedef struct {
        int          port;
        logic        upd;
        logic [DW-1:0] data;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int mode = 0;
    int busy_cnt = 0;
    logic [AW-1:0] cap;
    logic [AW-1:0] a [NP];
    logic [DW-1:0] m_rdata;
    exp_t sb [$];
    always #5 clk = ~clk;
    dram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();
    dram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus));
    // controller model: mode 0 normal, 1 never busy, 2 busy forced high
    always @(posedge clk) begin
        if (mode == 2) bus.mc_busy_i <= 1'b1;
        else if (mode == 1) bus.mc_busy_i <= 1'b0;
        else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                bus.mc_busy_i      <= 1'b0;
                bus.mc_read_data_i <= {16{cap[3:0]}};
            end
        end else begin
            bus.mc_busy_i <= 1'b0;
            if (bus.mc_read_o || bus.mc_write_o) begin
                bus.mc_busy_i      <= 1'b1;
                busy_cnt           <= BL;
                cap                <= bus.mc_address_o;
                bus.mc_read_data_i <= 64'hDEAD_BEEF_DEAD_BEEF;
            end
        end
    end
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_rdata = '0;
        end else begin
            if (bus.mc_read_o || bus.mc_write_o) begin
                checks++;
                if (bus.mc_read_o && bus.mc_write_o) begin
                    errors++;
                    $display("FAIL strobe_excl: rd=%b wr=%b, required at most one high", bus.mc_read_o, bus.mc_write_o);
                end
            end
            if (bus.gnt_o != 0) begin
                checks++;
                if ($countones(bus.gnt_o) != 1) begin
                    errors++;
                    $display("FAIL gnt_onehot: got %b", bus.gnt_o);
                end
                for (int p = 0; p < NP; p++)
                    if (bus.gnt_o[p]) sb.push_back('{p, !bus.we_i[p] && mode != 1, {16{a[p][3:0]}}});
            end
            if (bus.done_o != 0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done=%b with nothing outstanding", bus.done_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.upd) m_rdata = e.data;
                    if (bus.done_o !== NP'(1) << e.port || bus.rdata_o !== m_rdata || bus.gnt_o !== '0) begin
                        errors++;
                        $display("FAIL done_sb: done=%b rdata=%h gnt=%b, required done=%b rdata=%h gnt=0",
                                 bus.done_o, bus.rdata_o, bus.gnt_o, NP'(1) << e.port, m_rdata);
                    end
                end
            end
        end
    end
    task automatic load_addrs;
        for (int p = 0; p < NP; p++) bus.addr_i[p*AW +: AW] = a[p];
    endtask
    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask
    task automatic wait_gnt(output logic [NP-1:0] g);
        g = '0;
        for (int i = 0; i < 200 && g == 0; i++) begin
            @(negedge clk);
            g = bus.gnt_o;
        end
    endtask
    task automatic wait_idle;
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask
    task automatic test_reset;
        rst = 1'b1;
        bus.req_i = '1;
        @(negedge clk);
        checks++;
        if ({bus.gnt_o, bus.done_o, bus.err_o, bus.mc_read_o, bus.mc_write_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctl: gnt=%b done=%b err=%b rd=%b wr=%b, required all 0",
                     bus.gnt_o, bus.done_o, bus.err_o, bus.mc_read_o, bus.mc_write_o);
        end
        checks++;
        if (bus.rdata_o !== '0 || bus.mc_address_o !== '0 || bus.mc_write_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required 0", bus.rdata_o, bus.mc_address_o, bus.mc_write_data_o);
        end
        bus.req_i = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask
    task automatic test_write;
        logic [NP-1:0] g;
        int nstb, first, lastb, tdone;
        bit okd;
        a[0] = 27'h0000123;
        load_addrs();
        bus.we_i = 4'b0001;
        bus.wdata_i[0 +: DW] = 64'hA5A5_A5A5_A5A5_A5A5;
        @(posedge clk);
        #1 bus.req_i = 4'b0001;
        wait_gnt(g);
        checks++;
        if (g !== 4'b0001) begin
            errors++;
            $display("FAIL write_gnt: got %b, required 0001", g);
        end
        @(posedge clk);
        #1 bus.req_i = '0;
        nstb = 0; first = -1; lastb = -1; tdone = -1; okd = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.mc_write_o || bus.mc_read_o) begin
                nstb++;
                if (first < 0) first = i;
                if (bus.mc_read_o || bus.mc_address_o !== 27'h0000123 || bus.mc_write_data_o !== 64'hA5A5_A5A5_A5A5_A5A5) okd = 1'b0;
            end
            if (bus.mc_busy_i) lastb = i;
            if (bus.done_o != 0) begin
                tdone = i;
                break;
            end
        end
        checks++;
        if (nstb != 2 || first != 0) begin
            errors++;
            $display("FAIL write_strobe: %0d cycles starting at %0d, required 2 starting at 0", nstb, first);
        end
        checks++;
        if (!okd) begin
            errors++;
            $display("FAIL write_bus: addr/data/strobe kind wrong while strobing, required addr 123 data a5a5..");
        end
        checks++;
        if (tdone < 0 || tdone - lastb != 2) begin
            errors++;
            $display("FAIL write_done_lat: done at %0d last busy %0d, required 2 apart", tdone, lastb);
        end
        wait_idle();
        a[0] = 27'h1;
        load_addrs();
        bus.we_i = '0;
    endtask
    task automatic test_round_robin;
        int order [$];
        do_reset();
        bus.we_i = '0;
        @(posedge clk);
        #1 bus.req_i = 4'b1111;
        for (int i = 0; i < 400 && order.size() < 5; i++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) if (bus.gnt_o[p]) order.push_back(p);
            if (order.size() == 5) begin
                @(posedge clk);
                #1 bus.req_i = '0;
            end
        end
        bus.req_i = '0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= order.size() || order[k] != k % NP) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d, required %0d", k, k < order.size() ? order[k] : -1, k % NP);
            end
        end
        wait_idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: %0d outstanding, required 0", sb.size());
        end
    endtask
    task automatic test_two_ports;
        int order [$];
        do_reset();
        @(posedge clk);
        #1 bus.req_i = 4'b1010;
        for (int i = 0; i < 400 && order.size() < 4; i++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) if (bus.gnt_o[p]) order.push_back(p);
            if (order.size() == 4) begin
                @(posedge clk);
                #1 bus.req_i = '0;
            end
        end
        bus.req_i = '0;
        for (int k = 0; k < 4; k++) begin
            int ex;
`ifdef DRAM_ARB_FIXED_PRIORITY_EN
            ex = 1;
`else
            ex = k % 2 == 0 ? 1 : 3;
`endif
            checks++;
            if (k >= order.size() || order[k] != ex) begin
                errors++;
                $display("FAIL two_port_order[%0d]: got %0d, required %0d", k, k < order.size() ? order[k] : -1, ex);
            end
        end
        wait_idle();
    endtask
    task automatic test_timeout;
        logic [NP-1:0] g, d;
        int nstb;
        mode = 1;
        @(posedge clk);
        #1 bus.req_i = 4'b0100;
        wait_gnt(g);
        checks++;
        if (g !== 4'b0100) begin
            errors++;
            $display("FAIL tmo_gnt: got %b, required 0100", g);
        end
        @(posedge clk);
        #1 bus.req_i = '0;
        nstb = 0;
        d = '0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (bus.mc_read_o) nstb++;
            if (bus.done_o != 0) begin
                d = bus.done_o;
                break;
            end
        end
        checks++;
        if (nstb != TO || d !== 4'b0100) begin
            errors++;
            $display("FAIL tmo_expire: strobe %0d cycles done=%b, required %0d cycles done=0100", nstb, d, TO);
        end
        @(negedge clk);
        checks++;
        if (bus.err_o !== 1'b1 || bus.mc_read_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_err: err=%b rd=%b, required err=1 rd=0", bus.err_o, bus.mc_read_o);
        end
        mode = 0;
        bus.we_i = 4'b0010;
        @(posedge clk);
        #1 bus.req_i = 4'b0010;
        wait_gnt(g);
        @(posedge clk);
        #1 bus.req_i = '0;
        d = '0;
        for (int i = 0; i < 200 && d == 0; i++) begin
            @(negedge clk);
            d = bus.done_o;
        end
        checks++;
        if (g !== 4'b0010 || d !== 4'b0010 || bus.err_o !== 1'b1) begin
            errors++;
            $display("FAIL tmo_next: gnt=%b done=%b err=%b, required 0010 0010 1", g, d, bus.err_o);
        end
        bus.we_i = '0;
        wait_idle();
    endtask
    task automatic test_busy_hold;
        logic [NP-1:0] g;
        int ng;
        mode = 2;
        repeat (2) @(posedge clk);
        #1 bus.req_i = 4'b0010;
        ng = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.gnt_o != 0) ng++;
        end
        checks++;
        if (ng != 0) begin
            errors++;
            $display("FAIL busy_hold: %0d grants while busy, required 0", ng);
        end
        mode = 0;
        g = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.mc_busy_i) begin
                g = bus.gnt_o;
                break;
            end
        end
        checks++;
        if (g !== 4'b0010) begin
            errors++;
            $display("FAIL busy_release_gnt: got %b, required 0010", g);
        end
        @(posedge clk);
        #1 bus.req_i = '0;
        wait_idle();
        checks++;
        if (sb.size() != 0 || bus.err_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_drain: outstanding %0d err=%b, required 0 and 1", sb.size(), bus.err_o);
        end
    endtask
    task automatic test_reset_mid;
        logic [NP-1:0] g;
        int nb, nd;
        @(posedge clk);
        #1 bus.req_i = 4'b1000;
        wait_gnt(g);
        @(posedge clk);
        #1 bus.req_i = '0;
        nb = 0;
        for (int i = 0; i < 100 && nb < 3; i++) begin
            @(negedge clk);
            if (bus.mc_busy_i) nb++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.gnt_o, bus.done_o, bus.err_o, bus.mc_read_o, bus.mc_write_o} !== '0 ||
            bus.rdata_o !== '0 || bus.mc_address_o !== '0 || bus.mc_write_data_o !== '0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b done=%b err=%b rd=%b wr=%b rdata=%h addr=%h, required all 0",
                     bus.gnt_o, bus.done_o, bus.err_o, bus.mc_read_o, bus.mc_write_o, bus.rdata_o, bus.mc_address_o);
        end
        bus.req_i = 4'b1001;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        nd = 0;
        g = '0;
        for (int i = 0; i < 100 && g == 0; i++) begin
            @(negedge clk);
            if (bus.done_o != 0) nd++;
            g = bus.gnt_o;
        end
        checks++;
        if (nd != 0 || g !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset: %0d stray done, gnt=%b, required 0 done and gnt 0001", nd, g);
        end
        @(posedge clk);
        #1 bus.req_i = '0;
        wait_idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: %0d outstanding, required 0", sb.size());
        end
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int p = 0; p < NP; p++) a[p] = AW'(p + 1);
        load_addrs();
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.wdata_i = {NP{64'h0123_4567_89AB_CDEF}};
        test_reset();
        test_write();
        test_round_robin();
        test_two_ports();
        test_timeout();
        test_busy_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single-transaction DDR3 controller user interface (read/write strobe, address, write_data, read_data, busy) between NUM_PORTS requesters.
- Arbitrates round-robin, issues one transaction at a time, tracks controller busy to detect completion, and returns read data with a done pulse to the winning port.
- Sits between client logic and the DDR3 controller in the same clk_i domain.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8)
- ADDR_W, 27, bank+row+column address width (BA 3 + ROW 14 + COL 10)
- DATA_W, 64, burst data width (BL 8 x DQ 8)
- TIMEOUT, 1024, max cycles in WAIT_BUSY before error

Ports:
- clk_i  in  1  system clock (controller clock)
- rst_i  in  1  reset
- req_i  in  NUM_PORTS  per-port request; held until gnt_o
- we_i  in  NUM_PORTS  per-port 1=write, 0=read
- addr_i  in  NUM_PORTS*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
- wdata_i  in  NUM_PORTS*DATA_W  per-port write data, same packing
- gnt_o  out  NUM_PORTS  one-cycle one-hot pulse: request accepted
- done_o  out  NUM_PORTS  one-cycle one-hot pulse: transaction complete
- rdata_o  out  DATA_W  read data, valid with done_o of a read
- err_o  out  1  sticky timeout flag
- mc_read_o  out  1  read strobe to controller
- mc_write_o  out  1  write strobe to controller
- mc_address_o  out  ADDR_W  address to controller
- mc_write_data_o  out  DATA_W  write data to controller
- mc_read_data_i  in  DATA_W  read data from controller
- mc_busy_i  in  1  controller busy

Interface note: one clock; reset is asynchronous and active-high (clk_i, rst_i).

Behaviour:
- Reset (async, any state):
  - Outputs: gnt_o, done_o, rdata_o, err_o, mc_read_o, mc_write_o, mc_address_o, mc_write_data_o all 0.
  - State = IDLE; round-robin pointer last = NUM_PORTS-1, so port 0 wins first.
  - A reset mid-transaction abandons it; no done_o is issued.
- States:
  - IDLE: if mc_busy_i==0 and |req_i, pick winner w. Round-robin: first asserted port scanning last+1, last+2, ... modulo NUM_PORTS. Latch we/addr/wdata of w, pulse gnt_o[w], set last=w, go ISSUE. If mc_busy_i==1, nothing is granted.
  - ISSUE: drive mc_address_o/mc_write_data_o from latches; assert mc_write_o if write, else mc_read_o; clear timeout counter; go WAIT_BUSY.
  - WAIT_BUSY: hold strobe and address/data stable.
    - mc_busy_i==1: drop strobe, go WAIT_DONE.
    - Counter reaches TIMEOUT-1 first: drop strobe, set err_o, pulse done_o[w], go IDLE; rdata_o unchanged.
  - WAIT_DONE: hold address/data; on mc_busy_i==0 go CAPTURE. There is no timeout in this state.
  - CAPTURE: controller read_data is registered one cycle after busy falls, so sample mc_read_data_i here. If read, load rdata_o. Pulse done_o[w], go IDLE.
- Latency, idle bus, request to first strobe: gnt_o in cycle 0, strobe cycle 1. done_o comes 2 cycles after busy falls, counted from the last busy-high cycle.
- Only one strobe is ever high; strobes are never asserted while in IDLE/WAIT_DONE/CAPTURE.
- A request dropped before grant is not served. A request still high after done_o re-enters arbitration the next IDLE cycle, behind the other pending ports under round-robin.
- gnt_o and done_o never overlap for the same transaction; done_o for port w may coincide with no other pulse.
- err_o clears only on reset.
- Timeout counter: $clog2(TIMEOUT)+1 bits, saturating, never wraps.

Optional Feature:
- Macro: DRAM_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest-index asserted port always wins; the last pointer is unused.
- Undefined: round-robin as above.

Test Plan:
- Port 0 write, addr 0x0000123, wdata 0xA5A5..., busy model 1 cycle after strobe for 20 cycles -> gnt_o=0001, mc_write_o high exactly 2 cycles, done_o=0001 2 cycles after busy falls, rdata_o unchanged.
- Ports 0..3 all request reads continuously -> grant order 0,1,2,3,0; each done_o follows its gnt_o; rdata_o equals model data 0x1111..., 0x2222... per transaction.
- DRAM_ARB_FIXED_PRIORITY_EN defined, ports 1 and 3 held -> port 1 wins every time; port 3 starves while port 1 requests.
- Busy model never asserts -> after 1024 cycles strobe drops, err_o=1 stays set, done_o pulses for the winner, next request is still serviced.
- rst_i asserted in WAIT_DONE -> all outputs 0 immediately (async); no done_o; first post-reset grant goes to port 0.
- mc_busy_i held high while req_i=0010 -> no gnt_o until busy falls, then gnt_o=0010 the same cycle.
